// File: rtl/mbus_uart_tx_pkg.sv
// Shared register offsets, status bit positions and FSM state codes for the
// memory-bus UART transmitter.
package mbus_uart_tx_pkg;

    localparam logic [1:0] REG_DR  = 2'd0;
    localparam logic [1:0] REG_SR  = 2'd1;
    localparam logic [1:0] REG_DIV = 2'd2;
    localparam logic [1:0] REG_CR  = 2'd3;

    localparam int SR_TXACT     = 0;
    localparam int SR_FULL      = 1;
    localparam int SR_EMPTY     = 2;
    localparam int SR_OVF       = 3;
    localparam int SR_COUNT_LSB = 8;

    // state    | meaning
    // ST_IDLE  | line high, waiting for enable & queued byte
    // ST_START | start bit (low) on the line
    // ST_DATA  | eight data bits, LSB first
    // ST_STOP  | stop bit (high); may chain straight into the next frame
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/mbus_uart_tx_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mbus_uart_tx.sv
// Memory-bus UART transmitter: CPU-written bytes are queued and shifted out
// as 8N1 frames on txd, one bit per DIV+1 clocks.
module mbus_uart_tx
    import mbus_uart_tx_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          FIFO_AW     = 2,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             wen,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             txd,
    output logic             busy
);
    uart_state_e      state_q;
    logic [15:0]      cnt_q;
    logic [15:0]      div_q;
    logic [2:0]       bitcnt_q;
    logic [7:0]       shreg_q;
    logic             txd_q;
    logic             enable_q;
    logic             ovf_q;
    logic             ovf_d;

    logic             wr_en;
    logic             push;
    logic             pop;
    logic             txact;
    logic             bit_end;
    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    logic             unused_din;

    assign wr_en      = cs & wen;
    assign push       = wr_en & (addr == REG_DR);
    assign txact      = (state_q != ST_IDLE);
    assign bit_end    = (cnt_q == 16'd0);
    assign pop        = enable_q & ~fifo_empty &
                        ((state_q == ST_IDLE) | ((state_q == ST_STOP) & bit_end));
    assign txd        = txd_q;
    assign busy       = txact | ~fifo_empty;
    assign unused_din = ^din[WIDTH-1:16];

    sync_fifo #(.DW(8), .AW(FIFO_AW)) u_fifo (
        .clk_i   (clk),
        .rst_n_i (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (din[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A dropped push outranks a same-cycle clear so an overflow is never lost.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && addr == REG_SR && din[SR_OVF]) ovf_d = 1'b0;
        if (push && fifo_full && !pop)              ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q    <= DEFAULT_DIV;
            enable_q <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            if (wr_en && addr == REG_DIV) div_q    <= din[15:0];
            if (wr_en && addr == REG_CR)  enable_q <= din[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 16'd0;
            bitcnt_q <= 3'd0;
            shreg_q  <= 8'd0;
            txd_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        shreg_q <= fifo_rdata;
                        txd_q   <= 1'b0;
                        cnt_q   <= div_q;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        txd_q    <= shreg_q[0];
                        shreg_q  <= {1'b0, shreg_q[7:1]};
                        bitcnt_q <= 3'd0;
                        cnt_q    <= div_q;
                        state_q  <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt_q <= div_q;
                        if (bitcnt_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            txd_q    <= shreg_q[0];
                            shreg_q  <= {1'b0, shreg_q[7:1]};
                            bitcnt_q <= bitcnt_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shreg_q <= fifo_rdata;
                            txd_q   <= 1'b0;
                            cnt_q   <= div_q;
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            REG_SR: begin
                dout[SR_COUNT_LSB +: FIFO_AW+1] = fifo_count;
                dout[SR_OVF]   = ovf_q;
                dout[SR_EMPTY] = fifo_empty;
                dout[SR_FULL]  = fifo_full;
                dout[SR_TXACT] = txact;
            end
            REG_DIV: dout[15:0] = div_q;
            REG_CR:  dout[0]    = enable_q;
            default: dout = '0;
        endcase
    end

endmodule

// File: tb/tb_mbus_uart_tx.sv
// Directed bench for mbus_uart_tx: a line monitor decodes frames and checks
// them against a queue of bytes expected to be transmitted.
module tb_mbus_uart_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        wen;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        txd;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int         start_cyc[$];
    bit         mon_en  = 1'b0;
    int         mon_div = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mbus_uart_tx #(.WIDTH(32), .FIFO_AW(2), .DEFAULT_DIV(16'd433)) dut (
        .clk   (clk),
        .reset (reset),
        .cs    (cs),
        .wen   (wen),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .txd   (txd),
        .busy  (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; wen = 1'b1; addr = a; din = d;
        @(negedge clk);
        cs = 1'b0; wen = 1'b0; din = '0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        cs = 1'b1; wen = 1'b0; addr = a;
        #1;
        d  = dout;
        cs = 1'b0;
        check(tag, d, exp);
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < maxc), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Frame monitor: every cycle of every bit must hold the same level.
    always begin : monitor
        logic [7:0] rx;
        logic       first;
        bit         ok;
        int         d;
        @(negedge clk);
        if (mon_en && reset === 1'b1 && txd === 1'b0) begin
            start_cyc.push_back(cyc);
            d  = mon_div;
            ok = 1'b1;
            rx = '0;
            first = 1'b0;
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c <= d; c++) begin
                    if (k != 0 || c != 0) @(negedge clk);
                    if (c == 0) first = txd;
                    else if (txd !== first) ok = 1'b0;
                    if (k == 0 && txd !== 1'b0) ok = 1'b0;
                    if (k == 9 && txd !== 1'b1) ok = 1'b0;
                    if (k >= 1 && k <= 8 && c == 0) rx[k-1] = txd;
                end
            end
            check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("frame_byte", 32'(rx), 32'(exp_q.pop_front()));
            check("frame_shape", 32'(ok), 32'd1);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] b;
        logic       lvl;
        int         errs;

        reset = 1'b0; cs = 1'b0; wen = 1'b0; addr = '0; din = '0;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_reg("rst_sr", 2'd1, 32'h4);
        check_reg("rst_div", 2'd2, 32'd433);
        check_reg("rst_cr", 2'd3, 32'd1);
        check_reg("rst_dr", 2'd0, 32'd0);

        // 1: single byte, DIV=3, latency and exact frame length
        bus_write(2'd2, 32'd3);
        check_reg("t1_div_rb", 2'd2, 32'd3);
        mon_div = 3; mon_en = 1'b1;
        exp_q.push_back(8'hA5);
        bus_write(2'd0, 32'hA5);
        check("t1_txd_before", 32'(txd), 32'd1);
        check_reg("t1_sr_queued", 2'd1, 32'h100);
        @(negedge clk);
        check("t1_txd_start", 32'(txd), 32'd0);
        repeat (39) @(negedge clk);
        check("t1_stop_last", 32'({txd, busy}), 32'b11);
        @(negedge clk);
        check("t1_busy_fall", 32'(busy), 32'd0);
        wait_drain(100);

        // 2: fill while disabled, overflow, back-to-back frames
        bus_write(2'd2, 32'd1);
        mon_div = 1;
        bus_write(2'd3, 32'd0);
        start_cyc.delete();
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            bus_write(2'd0, 32'(i));
        end
        bus_write(2'd0, 32'hFF);
        check_reg("t2_sr_full_ovf", 2'd1, 32'h40A);
        check("t2_busy_queued", 32'(busy), 32'd1);
        bus_write(2'd3, 32'd1);
        wait_drain(300);
        check("t2_frames", 32'(start_cyc.size()), 32'd4);
        for (int i = 1; i < start_cyc.size(); i++)
            check("t2_gap", 32'(start_cyc[i] - start_cyc[i-1]), 32'd20);
        check_reg("t2_sr_ovf_sticky", 2'd1, 32'hC);
        bus_write(2'd1, 32'h8);
        check_reg("t2_sr_ovf_clr", 2'd1, 32'h4);

        // 3: DIV=0, push into a full FIFO on the cycle of a pop
        bus_write(2'd2, 32'd0);
        mon_div = 0;
        bus_write(2'd3, 32'd0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'(8'h11 * (i + 1)));
            bus_write(2'd0, 32'(8'h11 * (i + 1)));
        end
        check_reg("t3_sr_full", 2'd1, 32'h402);
        bus_write(2'd3, 32'd1);
        exp_q.push_back(8'h55);
        bus_write(2'd0, 32'h55);
        check_reg("t3_sr_push_on_pop", 2'd1, 32'h403);
        wait_drain(300);
        check_reg("t3_sr_done", 2'd1, 32'h4);

        // 4: DIV change mid-frame takes effect at the next bit boundary
        mon_en = 1'b0;
        bus_write(2'd2, 32'd1);
        b = 8'h96;
        bus_write(2'd0, 32'(b));
        @(negedge clk);
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            if (i < 2)       lvl = 1'b0;
            else if (i < 10) lvl = b[(i - 2) / 2];
            else if (i < 34) lvl = b[4 + (i - 10) / 6];
            else             lvl = 1'b1;
            if (txd !== lvl) errs++;
            if (i == 8) begin cs = 1'b1; wen = 1'b1; addr = 2'd2; din = 32'd5; end
            if (i == 9) begin cs = 1'b0; wen = 1'b0; din = '0; end
            @(negedge clk);
        end
        check("t4_trace_errs", 32'(errs), 32'd0);
        check("t4_idle_after", 32'({txd, busy}), 32'b10);
        check_reg("t4_div_rb", 2'd2, 32'd5);

        // 5: disable mid-frame with two bytes queued, then re-enable
        bus_write(2'd2, 32'd1);
        mon_div = 1; mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'(8'hA1 + i));
            bus_write(2'd0, 32'(8'hA1 + i));
        end
        repeat (3) @(negedge clk);
        bus_write(2'd3, 32'd0);
        repeat (30) @(negedge clk);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            if (txd !== 1'b1) errs++;
            @(negedge clk);
        end
        check("t5_held_high", 32'(errs), 32'd0);
        check_reg("t5_sr_kept", 2'd1, 32'h200);
        check("t5_busy_queued", 32'(busy), 32'd1);
        bus_write(2'd3, 32'd1);
        check("t5_txd_before", 32'(txd), 32'd1);
        @(negedge clk);
        check("t5_restart", 32'(txd), 32'd0);
        wait_drain(200);

        // 6: asynchronous reset in the middle of the data bits
        mon_en = 1'b0;
        bus_write(2'd2, 32'd3);
        for (int i = 0; i < 3; i++) bus_write(2'd0, 32'h00);
        repeat (8) @(negedge clk);
        check("t6_pre_low", 32'(txd), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("t6_async_txd", 32'(txd), 32'd1);
        check("t6_async_busy", 32'(busy), 32'd0);
        check_reg("t6_sr", 2'd1, 32'h4);
        check_reg("t6_div", 2'd2, 32'd433);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_idle", 32'({txd, busy}), 32'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
